// File: rtl/fst_out_uart_if.sv
// Core output port bundle for fst_out_uart: word strobe towards the UART,
// queue status back towards the core.
interface fst_out_uart_if #(
  parameter int DEPTH = 8
);
  logic                     out_en;
  logic [15:0]              out_dat;
  logic                     full;
  logic                     overflow;
  logic [$clog2(DEPTH):0]   level;

  modport master (
    output out_en, out_dat,
    input  full, overflow, level
  );

  modport slave (
    input  out_en, out_dat,
    output full, overflow, level
  );
endinterface

// File: rtl/fst_out_uart.sv
// Queues 16-bit core output words and sends each as two 8N1 UART frames, high byte first.
// Optional FST_OUT_UART_PARITY_EN adds an even-parity bit after the data bits.
module fst_out_uart #(
  parameter int DEPTH        = 8,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic          clk,
  input  logic          reset,
  fst_out_uart_if.slave core,
  output logic          tx,
  output logic          busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);

`ifdef FST_OUT_UART_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   level;
  logic          overflow;

  state_t        state;
  logic [15:0]   hold;
  logic          hi;
  logic [2:0]    idx;
  logic [CW-1:0] cnt;

  logic          full;
  logic          pop;
  logic          push;
  logic          bit_end;
  logic [7:0]    cur_byte;

  always_comb begin
    full     = (level == (AW+1)'(DEPTH));
    pop      = (state == IDLE) && (level != '0);
    // a same-cycle pop frees a slot, so a full queue can still accept
    push     = core.out_en && (!full || pop);
    bit_end  = (cnt == CW'(CLKS_PER_BIT - 1));
    cur_byte = hi ? hold[15:8] : hold[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset && push) begin
      mem[wr_ptr] <= core.out_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        level <= level + (AW+1)'(1);
      end else if (pop && !push) begin
        level <= level - (AW+1)'(1);
      end
      if (core.out_en && !push) begin
        overflow <= 1'b1;
      end
    end
  end

  // tx is loaded with the value of the state being entered, so it is
  // already correct in the first cycle of each bit
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      tx    <= 1'b1;
      hold  <= '0;
      hi    <= 1'b0;
      idx   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx  <= 1'b1;
          cnt <= '0;
          if (pop) begin
            hold  <= mem[rd_ptr];
            hi    <= 1'b1;
            state <= START;
            tx    <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            cnt   <= '0;
            idx   <= '0;
            state <= DATA;
            tx    <= cur_byte[0];
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt <= '0;
            if (idx == 3'd7) begin
`ifdef FST_OUT_UART_PARITY_EN
              state <= PARITY;
              tx    <= ^cur_byte;
`else
              state <= STOP;
              tx    <= 1'b1;
`endif
            end else begin
              idx <= idx + 3'd1;
              tx  <= cur_byte[idx + 3'd1];
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`ifdef FST_OUT_UART_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            cnt   <= '0;
            state <= STOP;
            tx    <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            cnt <= '0;
            if (hi) begin
              hi    <= 1'b0;
              state <= START;
              tx    <= 1'b0;
            end else begin
              state <= IDLE;
              tx    <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

  assign busy          = (state != IDLE) || (level != '0);
  assign core.full     = full;
  assign core.overflow = overflow;
  assign core.level    = level;
endmodule

// File: tb/tb_fst_out_uart.sv
// Bench for fst_out_uart: vector table for queue/overflow behaviour, a serial
// decoder feeding a word scoreboard, and hand sequences for timing corners.
module tb_fst_out_uart;
  localparam int DEPTH = 8;
  localparam int CPB   = 4;
`ifdef FST_OUT_UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int WLEN = 2 * NB * CPB;

  logic clk = 1'b0;
  logic reset;
  logic tx;
  logic busy;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] sb[$];

  fst_out_uart_if #(.DEPTH(DEPTH)) core_if();

  fst_out_uart #(.DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .reset (reset),
    .core  (core_if.slave),
    .tx    (tx),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [15:0] dat;
    logic        acc;
    logic [3:0]  lvl;
    logic        full;
    logic        ovf;
    logic        busy;
    logic        tx;
  } vec_t;

  vec_t vecs[11];
  logic wave[WLEN];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [10:0] frame_bits(input logic [7:0] b);
    logic [10:0] f;
    f    = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = b[i];
    if (NB == 11) f[9] = ^b;
    return f;
  endfunction

  // serial decoder: samples mid-bit, rebuilds words, pops the scoreboard
  int          mon_off;
  logic        mon_act = 1'b0;
  logic [10:0] mon_bits;
  logic        mon_have_hi = 1'b0;
  logic [7:0]  mon_hi;
  always @(negedge clk) begin
    if (!reset) begin
      mon_act     = 1'b0;
      mon_have_hi = 1'b0;
    end else begin
      if (!mon_act && tx == 1'b0) begin
        mon_act  = 1'b1;
        mon_off  = 0;
        mon_bits = '1;
      end
      if (mon_act) begin
        if (mon_off % CPB == CPB / 2) mon_bits[mon_off / CPB] = tx;
        if (mon_off == (NB - 1) * CPB + CPB / 2) begin
          mon_act = 1'b0;
          check("frame_fmt", mon_bits, frame_bits(mon_bits[8:1]));
          if (!mon_have_hi) begin
            mon_hi      = mon_bits[8:1];
            mon_have_hi = 1'b1;
          end else begin
            mon_have_hi = 1'b0;
            if (sb.size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL sb_unexpected: got word %04h expected none", {mon_hi, mon_bits[8:1]});
            end else begin
              check("sb_word", {mon_hi, mon_bits[8:1]}, sb.pop_front());
            end
          end
        end
        mon_off++;
      end
    end
  end

  task automatic drive(input logic en, input logic [15:0] d);
    core_if.out_en  = en;
    core_if.out_dat = d;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive(1'b0, '0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while ((sb.size() != 0 || busy) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check({name, "_pending"}, sb.size(), 0);
    check({name, "_busy"}, busy, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic word_wave(input string name, input logic [15:0] w);
    logic [10:0] fh;
    logic [10:0] fl;
    logic        exp;
    fh = frame_bits(w[15:8]);
    fl = frame_bits(w[7:0]);
    drive(1'b1, w);
    sb.push_back(w);
    @(negedge clk);
    drive(1'b0, '0);
    check({name, "_pre"}, tx, 1);
    for (int j = 0; j < WLEN; j++) begin
      @(negedge clk);
      if (j < NB * CPB) exp = fh[j / CPB];
      else              exp = fl[(j - NB * CPB) / CPB];
      wave[j] = tx;
      check(name, tx, exp);
    end
    @(negedge clk);
    check({name, "_idle_tx"}, tx, 1);
    check({name, "_idle_busy"}, busy, 0);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 16'h0001, 1'b1, 4'd1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[1]  = '{1'b1, 16'h0002, 1'b1, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 16'h0003, 1'b1, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 16'h0004, 1'b1, 4'd3, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 16'h0005, 1'b1, 4'd4, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 16'h0006, 1'b1, 4'd5, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 16'h0007, 1'b1, 4'd6, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 16'h0008, 1'b1, 4'd7, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 16'h0009, 1'b1, 4'd8, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 16'h000A, 1'b0, 4'd8, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 16'h0000, 1'b0, 4'd8, 1'b1, 1'b1, 1'b1, 1'b0};

    // reset held with the strobe active
    reset = 1'b0;
    drive(1'b1, 16'hDEAD);
    repeat (2) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_level", core_if.level, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf", core_if.overflow, 0);
    check("rst_full", core_if.full, 0);
    reset = 1'b1;
    drive(1'b0, '0);
    repeat (2) @(negedge clk);
    check("rst_no_enq_level", core_if.level, 0);
    check("rst_no_enq_busy", busy, 0);

    word_wave("single", 16'hA53C);
    drain("single_drain");

    // overflow table
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].en, vecs[i].dat);
      if (vecs[i].en && vecs[i].acc) sb.push_back(vecs[i].dat);
      @(negedge clk);
      check($sformatf("ovf_v%0d_level", i), core_if.level, vecs[i].lvl);
      check($sformatf("ovf_v%0d_full", i), core_if.full, vecs[i].full);
      check($sformatf("ovf_v%0d_ovf", i), core_if.overflow, vecs[i].ovf);
      check($sformatf("ovf_v%0d_busy", i), busy, vecs[i].busy);
      check($sformatf("ovf_v%0d_tx", i), tx, vecs[i].tx);
    end
    drive(1'b0, '0);
    drain("ovf_drain");
    check("ovf_sticky", core_if.overflow, 1);

    // full queue with a push in the popping cycle
    do_reset();
    check("fp_ovf_clr", core_if.overflow, 0);
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 16'h1100 + 16'(i));
      sb.push_back(16'h1100 + 16'(i));
      @(negedge clk);
    end
    drive(1'b0, '0);
    check("fp_level_full", core_if.level, 8);
    check("fp_full", core_if.full, 1);
    repeat (73) @(negedge clk);
    check("fp_level_prepop", core_if.level, 8);
    drive(1'b1, 16'h22CC);
    sb.push_back(16'h22CC);
    @(negedge clk);
    drive(1'b0, '0);
    check("fp_level_after", core_if.level, 8);
    check("fp_full_after", core_if.full, 1);
    check("fp_ovf_after", core_if.overflow, 0);
    drain("fp_drain");

    // reset during low-byte data bit 3 (a zero bit of 8'h34)
    drive(1'b1, 16'h1234);
    @(negedge clk);
    drive(1'b0, '0);
    repeat (NB * CPB + CPB * 4 + 2) @(negedge clk);
    check("mid_tx_low", tx, 0);
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_tx", tx, 1);
    check("mid_rst_level", core_if.level, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_full", core_if.full, 0);
    check("mid_rst_ovf", core_if.overflow, 0);
    @(negedge clk);
    reset = 1'b1;
    word_wave("after_rst", 16'hBEEF);
    drain("after_rst_drain");

`ifdef FST_OUT_UART_PARITY_EN
    word_wave("parity", 16'h0701);
    check("parity_hi_bit", wave[9 * CPB + CPB / 2], 1);
    check("parity_lo_bit", wave[NB * CPB + 9 * CPB + CPB / 2], 1);
    drain("parity_drain");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/fst_out_uart.md
# fst_out_uart

Output-side peripheral that consumes the core's `out_en`/`out_dat` strobe and serialises each 16-bit output word onto a UART TX line. Sits directly downstream of the core's output port. Words are queued in a small FIFO so the single-cycle core never stalls. Each word is sent as two 8N1 frames, high byte first.

## Interface
Parameters:
- `DEPTH`, 8: FIFO depth in 16-bit words. Power of two, ≥2.
- `CLKS_PER_BIT`, 434: clock cycles per UART bit. Must be ≥2.

Ports:
- `clk` input 1: single clock. All state updates on its rising edge.
- `reset` input 1: synchronous, active-low. Sampled on the `clk` rising edge.
- `out_en` input 1: core output strobe. One word is offered per cycle it is high.
- `out_dat` input 16: core output word, valid when `out_en` = 1.
- `tx` output 1: UART serial line. Idle high.
- `busy` output 1: high while a frame is in progress or the FIFO is non-empty.
- `full` output 1: FIFO holds `DEPTH` words.
- `overflow` output 1: sticky. Set when a word is dropped. Cleared only by reset.
- `level` output $clog2(DEPTH)+1: current FIFO occupancy.

## Operation
- Reset (`reset` = 0 at an edge) clears all state:
  - FIFO empty; `level` = 0, `full` = 0, `busy` = 0, `overflow` = 0.
  - `tx` = 1; FSM in IDLE.
  - Reset takes effect mid-frame too. `tx` returns high on the next cycle and the partial frame is abandoned.
- FIFO:
  - Circular buffer with read/write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH.
  - `level` counts 0..DEPTH.
  - Push: `out_en` = 1 and (not full, or a pop occurs the same cycle). The word is written at the write pointer.
  - `out_en` = 1 while full with no same-cycle pop: the word is discarded and `overflow` ← 1. FIFO contents and pointers are unchanged.
  - Pop: only in IDLE when `level` ≠ 0. The head word is loaded into a 16-bit shift holding register.
  - Simultaneous push and pop: `level` is unchanged and both pointers advance.
- TX FSM states: IDLE, START, DATA, STOP. A byte-select bit `hi` indicates which byte is being sent.
  - IDLE: `tx` = 1. If `level` ≠ 0: pop, set `hi` = 1, go to START.
  - START: `tx` = 0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: `tx` = current byte bit [idx], LSB first. Each bit lasts CLKS_PER_BIT cycles. After bit 7, go to STOP (or to PARITY when enabled, see Configuration).
  - STOP: `tx` = 1 for CLKS_PER_BIT cycles.
    - If `hi` = 1: clear `hi` and go to START for the low byte.
    - Otherwise go to IDLE.
- Current byte = holding[15:8] when `hi` = 1, else holding[7:0].
- Baud counter counts 0..CLKS_PER_BIT-1 and wraps at the end of every bit. It is held at 0 in IDLE.
- `busy` = (state ≠ IDLE) or (`level` ≠ 0).

## Timing
- `tx` is registered; no combinational path from inputs to `tx`.
- Push latency: `out_en` in cycle N → `level` increments and `full` updates in cycle N+1.
- Start latency: FIFO empty and IDLE, `out_en` in cycle N → IDLE pops at the end of N+1 → `tx` falls in cycle N+2.
- Word duration: 2 × 10 × CLKS_PER_BIT cycles (2 × 11 with parity).
- Back-to-back words: one IDLE cycle between the last STOP bit and the next start bit.
- `overflow` rises the cycle after the dropping strobe.

## Configuration
- `FST_OUT_UART_PARITY_EN`:
  - Defined: a PARITY state follows DATA. It drives the even parity of the current byte (XOR of its 8 bits) for CLKS_PER_BIT cycles, then goes to STOP. Each frame is 11 bits.
  - Undefined: there is no PARITY state and DATA goes directly to STOP. Each frame is 10 bits.

## Test plan
- Reset:
  - Stimulus: hold `reset` = 0 for 2 cycles with `out_en` = 1.
  - Required: `tx` = 1, `level` = 0, `busy` = 0, `overflow` = 0, and no word is enqueued.
- Single word (CLKS_PER_BIT = 4):
  - Stimulus: push 16'hA53C.
  - Required: `tx` falls 2 cycles after the strobe.
  - Sampled bits: 0, then 0xA5 LSB-first (1,0,1,0,0,1,0,1), then 1, then 0, then 0x3C LSB-first, then 1.
  - Total: 80 cycles; `busy` drops afterwards.
- Overflow (DEPTH = 8):
  - Stimulus: 10 consecutive strobes of 0x0001..0x000A while TX is busy.
  - Required: 0x0001 pops immediately and 0x0002..0x0009 fill the FIFO. `full` = 1 and 0x000A is dropped.
  - Required: `overflow` = 1 from the cycle after the drop. Output order on `tx` is 0x0001..0x0009.
- Full with simultaneous pop:
  - Stimulus: FIFO full and FSM returning to IDLE; assert `out_en` in the popping cycle.
  - Required: the word is accepted, `level` stays 8, and `overflow` stays 0.
- Reset mid-frame:
  - Stimulus: assert `reset` during a DATA bit of the low byte.
  - Required: `tx` = 1 the next cycle and all status outputs are at reset values.
  - Required: a new word pushed after release transmits correctly.
- Parity (macro defined):
  - Stimulus: push 16'h0701.
  - Required: the high-byte frame has parity bit 1 and the low-byte frame has parity bit 1.
  - Required: word length is 88 cycles at CLKS_PER_BIT = 4.
